vga_vline_sched: RTL and testbench

- Scanline scheduler that time-shares one vga_vline drawing unit among up to N_ENTRIES vertical-line descriptors, such as graticule lines and cursors.
- A host writes descriptors into a shadow table. The shadow table is copied to the live table at frame start.
- During each horizontal blank, a scan FSM compacts the live entries whose y-range covers the next line into an active list.
- During the visible line, the scheduler presents the active entries one at a time on the vl_* outputs, which drive the x/y0/y1/colour/dot_mode inputs of vga_vline.

---
 rtl/vga_vline_sched_if.sv | 28 ++
 rtl/vga_vline_sched.sv | 165 ++++++++++++++++
 tb/tb_vga_vline_sched.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_vline_sched_if.sv
// Host descriptor write port and drawn-line outputs of the vertical-line scheduler.
interface vga_vline_sched_if #(
  parameter int AW = 4
);
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic          cfg_en;
  logic [9:0]    cfg_x;
  logic [9:0]    cfg_y0;
  logic [9:0]    cfg_y1;
  logic [4:0]    cfg_colour;
  logic [1:0]    cfg_dot_mode;
  logic [9:0]    vl_x;
  logic [9:0]    vl_y0;
  logic [9:0]    vl_y1;
  logic [4:0]    vl_colour;
  logic [1:0]    vl_dot_mode;

  modport master (
    output cfg_we, cfg_addr, cfg_en, cfg_x, cfg_y0, cfg_y1, cfg_colour, cfg_dot_mode,
    input  vl_x, vl_y0, vl_y1, vl_colour, vl_dot_mode
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_en, cfg_x, cfg_y0, cfg_y1, cfg_colour, cfg_dot_mode,
    output vl_x, vl_y0, vl_y1, vl_colour, vl_dot_mode
  );
endinterface

// File: rtl/vga_vline_sched.sv
// Time-shares one vga_vline unit across a descriptor table: N_ENTRIES-cycle scan per line,
// then registered presentation of active entries; no backpressure. VGA_VLINE_SCHED_STATS_EN adds drop_cnt.
module vga_vline_sched #(
  parameter int N_ENTRIES = 16,
  parameter int AW        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              line_start,
  input  logic              frame_start,
  vga_vline_sched_if.slave  bus,
  output logic              sched_busy,
`ifdef VGA_VLINE_SCHED_STATS_EN
  output logic [15:0]       drop_cnt,
`endif
  output logic              scan_overrun
);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y0;
    logic [9:0] y1;
    logic [4:0] colour;
    logic [1:0] dot_mode;
  } line_t;

  typedef struct packed {
    logic  en;
    line_t ln;
  } desc_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;

  localparam line_t IDLE_LINE = '{x: 10'h3FF, y0: 10'd0, y1: 10'd0, colour: 5'd0, dot_mode: 2'd0};

  desc_t         shadow [N_ENTRIES];
  desc_t         live   [N_ENTRIES];
  line_t         act    [N_ENTRIES];

  logic [1:0]    state;
  logic [9:0]    ly;
  logic [AW-1:0] idx;
  logic [AW:0]   act_cnt;
  logic [AW:0]   ptr;
  line_t         vl;

  desc_t         cur;
  logic          hit;
  logic          last;
  logic [AW:0]   act_cnt_nxt;
  line_t         first_line;
  logic [AW:0]   ptr_nxt;
  line_t         next_line;
  logic          advance;

  assign cur         = live[idx];
  assign hit         = cur.en && (cur.ln.y0 <= ly) && (ly <= cur.ln.y1);
  assign last        = (idx == AW'(N_ENTRIES - 1));
  assign act_cnt_nxt = act_cnt + {{AW{1'b0}}, hit};
  // The final scanned entry may land in act[0] on the same edge that DRAW loads it.
  assign first_line  = (act_cnt == '0) ? cur.ln : act[0];
  assign ptr_nxt     = ptr + 1'b1;
  assign next_line   = (ptr_nxt < act_cnt) ? act[ptr_nxt[AW-1:0]] : IDLE_LINE;
  assign advance     = (state == DRAW) && (ptr < act_cnt) && (pix_x >= vl.x);

  assign sched_busy      = (state == SCAN);
  assign bus.vl_x        = vl.x;
  assign bus.vl_y0       = vl.y0;
  assign bus.vl_y1       = vl.y1;
  assign bus.vl_colour   = vl.colour;
  assign bus.vl_dot_mode = vl.dot_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        shadow[i] <= '0;
        live[i]   <= '0;
      end
    end else begin
      // Live copy takes the shadow as it stood before any same-cycle host write.
      if (frame_start) begin
        for (int i = 0; i < N_ENTRIES; i++) live[i] <= shadow[i];
      end
      if (bus.cfg_we) begin
        shadow[bus.cfg_addr] <= '{en: bus.cfg_en,
                                  ln: '{x: bus.cfg_x, y0: bus.cfg_y0, y1: bus.cfg_y1,
                                        colour: bus.cfg_colour, dot_mode: bus.cfg_dot_mode}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == SCAN) && !line_start && hit) act[act_cnt[AW-1:0]] <= cur.ln;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ly           <= '0;
      idx          <= '0;
      act_cnt      <= '0;
      ptr          <= '0;
      vl           <= IDLE_LINE;
      scan_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (line_start) begin
            state   <= SCAN;
            ly      <= pix_y;
            idx     <= '0;
            act_cnt <= '0;
          end
        end
        SCAN: begin
          if (line_start) begin
            ly           <= pix_y;
            idx          <= '0;
            act_cnt      <= '0;
            scan_overrun <= 1'b1;
          end else begin
            act_cnt <= act_cnt_nxt;
            if (last) begin
              state <= DRAW;
              ptr   <= '0;
              vl    <= (act_cnt_nxt == '0) ? IDLE_LINE : first_line;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DRAW: begin
          if (line_start) begin
            state   <= SCAN;
            ly      <= pix_y;
            idx     <= '0;
            act_cnt <= '0;
            vl      <= IDLE_LINE;
          end else if (advance) begin
            ptr <= ptr_nxt;
            vl  <= next_line;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VGA_VLINE_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (frame_start) begin
      drop_cnt <= '0;
    end else if (advance && (pix_x > vl.x) && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_vline_sched.sv
// Directed bench for vga_vline_sched: per-pixel vector table plus swap/overrun/reset sequences.
module tb_vga_vline_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       line_start = 1'b0;
  logic       frame_start = 1'b0;
  logic       sched_busy;
  logic       scan_overrun;
`ifdef VGA_VLINE_SCHED_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  vga_vline_sched_if #(.AW(4)) bus ();

  vga_vline_sched #(.N_ENTRIES(16), .AW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .bus          (bus.slave),
    .sched_busy   (sched_busy),
`ifdef VGA_VLINE_SCHED_STATS_EN
    .drop_cnt     (drop_cnt),
`endif
    .scan_overrun (scan_overrun)
  );

  always #20 clk = ~clk;

  typedef struct {
    bit         start;
    logic [9:0] y;
    logic [9:0] px;
    logic [9:0] ex;
    logic [4:0] ecol;
    logic [1:0] emode;
  } vec_t;

  vec_t vt [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic en, input logic [9:0] x,
                             input logic [9:0] y0, input logic [9:0] y1,
                             input logic [4:0] col, input logic [1:0] mode, input logic with_frame);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_en = en; bus.cfg_x = x;
    bus.cfg_y0 = y0; bus.cfg_y1 = y1; bus.cfg_colour = col; bus.cfg_dot_mode = mode;
    frame_start = with_frame;
    tick();
    bus.cfg_we = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Pulses line_start and counts busy cycles, giving up after 40.
  task automatic run_line(input logic [9:0] y, output int n);
    line_start = 1'b1; pix_y = y; pix_x = 10'd0;
    tick();
    line_start = 1'b0;
    n = 0;
    while (sched_busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic apply_px(input logic [9:0] px, output logic [9:0] seen);
    pix_x = px;
    @(negedge clk);
    seen = bus.vl_x;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         n;
    logic [9:0] seen;

    vt[0]  = '{1'b1, 10'd15, 10'd0,   10'd100,  5'd3,  2'd0};
    vt[1]  = '{1'b0, 10'd15, 10'd99,  10'd100,  5'd3,  2'd0};
    vt[2]  = '{1'b0, 10'd15, 10'd100, 10'd100,  5'd3,  2'd0};
    vt[3]  = '{1'b0, 10'd15, 10'd101, 10'h3FF,  5'd0,  2'd0};
    vt[4]  = '{1'b0, 10'd15, 10'd300, 10'h3FF,  5'd0,  2'd0};
    vt[5]  = '{1'b1, 10'd21, 10'd0,   10'h3FF,  5'd0,  2'd0};
    vt[6]  = '{1'b0, 10'd21, 10'd100, 10'h3FF,  5'd0,  2'd0};
    vt[7]  = '{1'b1, 10'd35, 10'd0,   10'd200,  5'd7,  2'd1};
    vt[8]  = '{1'b0, 10'd35, 10'd199, 10'd200,  5'd7,  2'd1};
    vt[9]  = '{1'b0, 10'd35, 10'd200, 10'd200,  5'd7,  2'd1};
    vt[10] = '{1'b0, 10'd35, 10'd201, 10'd201,  5'd9,  2'd2};
    vt[11] = '{1'b0, 10'd35, 10'd202, 10'd150,  5'd12, 2'd3};
    vt[12] = '{1'b0, 10'd35, 10'd203, 10'h3FF,  5'd0,  2'd0};
    vt[13] = '{1'b1, 10'd20, 10'd100, 10'd100,  5'd3,  2'd0};
    vt[14] = '{1'b0, 10'd20, 10'd101, 10'h3FF,  5'd0,  2'd0};
    vt[15] = '{1'b1, 10'd10, 10'd100, 10'd100,  5'd3,  2'd0};

    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_en = 1'b0; bus.cfg_x = '0;
    bus.cfg_y0 = '0; bus.cfg_y1 = '0; bus.cfg_colour = '0; bus.cfg_dot_mode = '0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_vl_x", bus.vl_x, 10'h3FF);
    check("reset_vl_y0", bus.vl_y0, 10'd0);
    check("reset_vl_y1", bus.vl_y1, 10'd0);
    check("reset_vl_colour", bus.vl_colour, 5'd0);
    check("reset_vl_dot_mode", bus.vl_dot_mode, 2'd0);
    check("reset_busy", sched_busy, 1'b0);
    check("reset_overrun", scan_overrun, 1'b0);

    write_entry(4'd0, 1'b1, 10'd100, 10'd10, 10'd20, 5'd3,  2'd0, 1'b0);
    write_entry(4'd1, 1'b1, 10'd200, 10'd30, 10'd40, 5'd7,  2'd1, 1'b0);
    write_entry(4'd2, 1'b1, 10'd201, 10'd30, 10'd40, 5'd9,  2'd2, 1'b0);
    write_entry(4'd3, 1'b1, 10'd150, 10'd30, 10'd40, 5'd12, 2'd3, 1'b0);
    write_entry(4'd5, 1'b0, 10'd50,  10'd0,  10'd100, 5'd1, 2'd1, 1'b0);

    run_line(10'd15, n);
    check("busy_len_pre_swap", n, 16);
    apply_px(10'd0, seen);
    check("live_empty_before_frame", seen, 10'h3FF);
    next_cycle();

    frame();
    for (int i = 0; i < 16; i++) begin
      if (vt[i].start) begin
        run_line(vt[i].y, n);
        check($sformatf("busy_len_y%0d", vt[i].y), n, 16);
      end
      pix_x = vt[i].px;
      @(negedge clk);
      check($sformatf("vec%0d_vl_x", i), bus.vl_x, vt[i].ex);
      check($sformatf("vec%0d_colour", i), bus.vl_colour, vt[i].ecol);
      check($sformatf("vec%0d_mode", i), bus.vl_dot_mode, vt[i].emode);
      next_cycle();
    end
`ifdef VGA_VLINE_SCHED_STATS_EN
    check("drop_cnt_after_table", drop_cnt, 16'd1);
`endif

    run_line(10'd15, n);
    pix_x = 10'd0;
    @(negedge clk);
    check("line15_y0", bus.vl_y0, 10'd10);
    check("line15_y1", bus.vl_y1, 10'd20);
    next_cycle();

    // Shadow write without a frame_start must not be visible yet.
    write_entry(4'd0, 1'b1, 10'd300, 10'd10, 10'd20, 5'd3, 2'd0, 1'b0);
    run_line(10'd15, n);
    apply_px(10'd0, seen);
    check("swap_no_frame", seen, 10'd100);
    next_cycle();
    write_entry(4'd0, 1'b1, 10'd350, 10'd10, 10'd20, 5'd3, 2'd0, 1'b1);
    run_line(10'd15, n);
    apply_px(10'd0, seen);
    check("swap_pre_write_value", seen, 10'd300);
    next_cycle();
    frame();
    run_line(10'd15, n);
    apply_px(10'd0, seen);
    check("swap_second_frame", seen, 10'd350);
    next_cycle();
`ifdef VGA_VLINE_SCHED_STATS_EN
    check("drop_cnt_cleared", drop_cnt, 16'd0);
`endif

    check("overrun_before", scan_overrun, 1'b0);
    line_start = 1'b1; pix_y = 10'd15; pix_x = 10'd0;
    tick();
    line_start = 1'b0;
    repeat (4) tick();
    run_line(10'd35, n);
    check("overrun_flag", scan_overrun, 1'b1);
    check("overrun_restart_len", n, 16);
    apply_px(10'd0, seen);
    check("overrun_new_line", seen, 10'd200);
    next_cycle();
    run_line(10'd15, n);
    check("overrun_sticky", scan_overrun, 1'b1);

    line_start = 1'b1; pix_y = 10'd35;
    tick();
    line_start = 1'b0;
    repeat (3) tick();
    check("busy_mid_scan", sched_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_scan_busy", sched_busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    write_entry(4'd1, 1'b1, 10'd200, 10'd30, 10'd40, 5'd7, 2'd1, 1'b0);
    frame();
    run_line(10'd35, n);
    apply_px(10'd150, seen);
    check("draw_before_reset", seen, 10'd200);
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("reset_draw_vl_x", bus.vl_x, 10'h3FF);
    check("reset_draw_busy", sched_busy, 1'b0);
    check("reset_draw_overrun", scan_overrun, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    run_line(10'd35, n);
    apply_px(10'd0, seen);
    check("live_disabled_after_reset", seen, 10'h3FF);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
